// File: rtl/sme_pkg.sv
// Shared definitions for the SME match path: index width, collector state
// encoding and the wrapper's next_index -> match_valid update latency.
package sme_pkg;

  localparam int MATCH_IDX_W     = 16;
  localparam int HOLDOFF_DEFAULT = 2;

  typedef enum logic {
    IDLE,
    HOLD
  } collector_state_e;

endpackage

// File: rtl/simple_fifo.sv
// First-word-fall-through FIFO: rd_data always shows the head entry while
// empty is low. Writes when full and reads when empty are ignored.
module simple_fifo #(
  parameter int ADDR_WIDTH = 3,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clear,
  input  logic                  wr_en,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic                  rd_en,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  full,
  output logic                  empty
);

  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [ADDR_WIDTH-1:0] wr_ptr_q, rd_ptr_q;
  logic [ADDR_WIDTH:0]   count_q;
  logic                  push, pop;

  assign full    = (count_q == (ADDR_WIDTH+1)'(DEPTH));
  assign empty   = (count_q == '0);
  assign push    = wr_en && !full;
  assign pop     = rd_en && !empty;
  assign rd_data = mem_q[rd_ptr_q];

  // NOTE: sequential state is updated only with non-blocking assignments so
  // every register samples the pre-edge values of its neighbours.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + ADDR_WIDTH'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + ADDR_WIDTH'(1);
      case ({push, pop})
        2'b10:   count_q <= count_q + (ADDR_WIDTH+1)'(1);
        2'b01:   count_q <= count_q - (ADDR_WIDTH+1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // NOTE: storage has no reset; the pointers and count alone define which
  // entries are meaningful, so the array can map onto plain RAM.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/sme_match_collector.sv
// Drains the SME wrapper's one-at-a-time match report into a FIFO and
// presents the rule indices as an AXI-Stream, with a per-packet match limit.
module sme_match_collector
  import sme_pkg::*;
#(
  parameter int DEPTH       = 8,
  parameter int MAX_MATCHES = 32,
  parameter int HOLDOFF     = HOLDOFF_DEFAULT,
  parameter int CNT_W       = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   reload,
  input  logic [MATCH_IDX_W-1:0] match_index,
  input  logic                   match_valid,
  output logic                   next_index,
  output logic [MATCH_IDX_W-1:0] m_axis_tdata,
  output logic                   m_axis_tvalid,
  input  logic                   m_axis_tready,
  output logic [CNT_W-1:0]       match_count,
  output logic                   overflow,
  output logic                   busy
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam int HC_W   = $clog2(HOLDOFF + 1);

  collector_state_e state_q, state_d;
  logic [HC_W-1:0]  hold_cnt_q, hold_cnt_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overflow_q, overflow_d;
  logic             next_index_q, next_index_d;
  logic             capture;
  logic             fifo_full, fifo_empty;

  // NOTE: every variable gets a default before the case so no path can leave
  // it unassigned and infer a latch.
  always_comb begin
    state_d      = state_q;
    hold_cnt_d   = hold_cnt_q;
    count_d      = count_q;
    overflow_d   = overflow_q;
    next_index_d = 1'b0;
    capture      = 1'b0;
    if (reload) begin
      state_d    = IDLE;
      hold_cnt_d = '0;
      count_d    = '0;
      overflow_d = 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (match_valid) begin
            if (count_q < CNT_W'(MAX_MATCHES)) begin
              // A full FIFO is plain backpressure: the index waits in the wrapper.
              if (!fifo_full) begin
                capture      = 1'b1;
                next_index_d = 1'b1;
                count_d      = count_q + CNT_W'(1);
                hold_cnt_d   = HC_W'(HOLDOFF);
                state_d      = HOLD;
              end
            end else begin
              overflow_d = 1'b1;
            end
          end
        end
        HOLD: begin
          if (hold_cnt_q <= HC_W'(1)) state_d    = IDLE;
          else                        hold_cnt_d = hold_cnt_q - HC_W'(1);
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      hold_cnt_q   <= '0;
      count_q      <= '0;
      overflow_q   <= 1'b0;
      next_index_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      hold_cnt_q   <= hold_cnt_d;
      count_q      <= count_d;
      overflow_q   <= overflow_d;
      next_index_q <= next_index_d;
    end
  end

  simple_fifo #(
    .ADDR_WIDTH (ADDR_W),
    .DATA_WIDTH (MATCH_IDX_W)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .clear   (reload),
    .wr_en   (capture),
    .wr_data (match_index),
    .rd_en   (m_axis_tready),
    .rd_data (m_axis_tdata),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_axis_tvalid = !fifo_empty;
  assign next_index    = next_index_q;
  assign match_count   = count_q;
  assign overflow      = overflow_q;
  assign busy          = (state_q != IDLE) || !fifo_empty;

endmodule

// File: tb/tb_sme_match_collector.sv
// Bench for sme_match_collector: a queue-based wrapper model feeds indices,
// and a per-packet scoreboard predicts the stream, count and overflow.
module tb_sme_match_collector;

  localparam int DEPTH   = 8;
  localparam int MAX     = 10;
  localparam int HOLDOFF = 2;

  logic        clk = 1'b0;
  logic        rst, reload, match_valid, next_index;
  logic        m_axis_tvalid, m_axis_tready, overflow, busy;
  logic [15:0] match_index, m_axis_tdata;
  logic [7:0]  match_count;

  always #5 clk = ~clk;

  sme_match_collector #(
    .DEPTH       (DEPTH),
    .MAX_MATCHES (MAX),
    .HOLDOFF     (HOLDOFF),
    .CNT_W       (8)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .reload        (reload),
    .match_index   (match_index),
    .match_valid   (match_valid),
    .next_index    (next_index),
    .m_axis_tdata  (m_axis_tdata),
    .m_axis_tvalid (m_axis_tvalid),
    .m_axis_tready (m_axis_tready),
    .match_count   (match_count),
    .overflow      (overflow),
    .busy          (busy)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int cyc = 0, pulses = 0, last_pulse = 0;
  bit strict_gap = 1'b0;
  logic [15:0] wq[$];     // indices still held by the wrapper
  logic [15:0] exp_q[$];  // indices expected on the stream, in order

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
    n_checks++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
  endtask

  task automatic drive_wrapper();
    match_valid = (wq.size() > 0);
    if (wq.size() > 0) match_index = wq[0];
    else               match_index = 16'($urandom);
  endtask

  task automatic model_clear();
    wq.delete();
    exp_q.delete();
    pulses = 0;
  endtask

  // Advance one cycle, observe just after the edge, then drive the next cycle.
  task automatic step(input bit rdy);
    @(posedge clk);
    #1;
    cyc++;
    if (next_index) begin
      if (pulses > 0) begin
        if (strict_gap) check("burst_gap", cyc - last_pulse, HOLDOFF + 1);
        else            check("min_gap", 32'((cyc - last_pulse) >= HOLDOFF + 1), 1);
      end
      pulses++;
      last_pulse = cyc;
      if (wq.size() > 0) void'(wq.pop_front());
      else               check("spurious_next_index", 1, 0);
    end
    m_axis_tready = rdy;
    if (m_axis_tvalid && rdy) begin
      if (exp_q.size() > 0) check("tdata", m_axis_tdata, exp_q.pop_front());
      else                  check("unexpected_beat", 1, 0);
    end
    drive_wrapper();
  endtask

  task automatic do_reload();
    reload = 1'b1;
    model_clear();
    step(1'b0);
    reload = 1'b0;
  endtask

  task automatic load_packet(input int n);
    for (int i = 0; i < n; i++) begin
      logic [15:0] idx;
      idx = ($urandom_range(0, 3) == 0) ? 16'h0000 : 16'($urandom);
      wq.push_back(idx);
      if (i < MAX) exp_q.push_back(idx);
    end
    drive_wrapper();
  endtask

  task automatic drain(input int max_cycles, input bit random_rdy);
    bit done;
    done = 1'b0;
    for (int i = 0; i < max_cycles && !done; i++) begin
      if (exp_q.size() == 0 && !busy && (wq.size() == 0 || pulses >= MAX)) done = 1'b1;
      else step(random_rdy ? ($urandom_range(0, 9) < 7) : 1'b1);
    end
    if (!done) check("drain_timeout", 1, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; reload = 1'b0; match_valid = 1'b0; match_index = '0; m_axis_tready = 1'b0;
    repeat (3) step(1'b0);
    check("rst_next_index", next_index, 0);
    check("rst_tvalid", m_axis_tvalid, 0);
    check("rst_count", match_count, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    rst = 1'b0;
    step(1'b0);

    // Single match: capture in cycle t, pulse and data visible at t+1.
    wq.push_back(16'h0123); exp_q.push_back(16'h0123); drive_wrapper();
    step(1'b0);
    check("single_ni_t1", next_index, 1);
    check("single_tvalid", m_axis_tvalid, 1);
    check("single_tdata", m_axis_tdata, 16'h0123);
    check("single_count", match_count, 1);
    check("single_busy", busy, 1);
    step(1'b0);
    check("single_ni_t2", next_index, 0);
    check("single_tdata_held", m_axis_tdata, 16'h0123);
    drain(50, 1'b0);
    check("single_count_end", match_count, 1);
    check("single_busy_end", busy, 0);

    // Burst: three matches, pulses exactly HOLDOFF+1 apart.
    do_reload();
    strict_gap = 1'b1;
    wq = '{16'h0010, 16'h0020, 16'h0030}; exp_q = wq; drive_wrapper();
    drain(100, 1'b0);
    strict_gap = 1'b0;
    check("burst_count", match_count, 3);
    check("burst_pulses", pulses, 3);

    // Backpressure: nine pending, FIFO of eight, sink stalled.
    do_reload();
    load_packet(9);
    repeat (40) step(1'b0);
    check("bp_pulses", pulses, 8);
    check("bp_count", match_count, 8);
    check("bp_overflow", overflow, 0);
    check("bp_next_index", next_index, 0);
    check("bp_tvalid", m_axis_tvalid, 1);
    check("bp_head", m_axis_tdata, exp_q[0]);
    drain(200, 1'b0);
    check("bp_count_end", match_count, 9);
    check("bp_pulses_end", pulses, 9);

    // Limit: twelve offered, MAX captured, overflow sticky.
    do_reload();
    load_packet(MAX + 2);
    drain(300, 1'b0);
    repeat (3) step(1'b1);
    check("lim_count", match_count, MAX);
    check("lim_overflow", overflow, 1);
    check("lim_pulses", pulses, MAX);
    check("lim_left", wq.size(), 2);
    repeat (5) step(1'b1);
    check("lim_overflow_sticky", overflow, 1);

    // Reload mid-HOLD with two entries buffered.
    do_reload();
    check("reload_clr_overflow", overflow, 0);
    check("reload_clr_count", match_count, 0);
    load_packet(3);
    for (int i = 0; i < 20 && pulses < 2; i++) step(1'b0);
    check("mh_two_captured", pulses, 2);
    check("mh_busy", busy, 1);
    reload = 1'b1;
    model_clear();
    step(1'b0);
    reload = 1'b0;
    check("mh_tvalid", m_axis_tvalid, 0);
    check("mh_count", match_count, 0);
    check("mh_overflow", overflow, 0);
    check("mh_busy_idle", busy, 0);
    check("mh_next_index", next_index, 0);

    // Reload coincident with match_valid: no capture until reload drops.
    reload = 1'b1;
    pulses = 0;
    wq = '{16'h0abc}; exp_q = wq; drive_wrapper();
    step(1'b0);
    reload = 1'b0;
    check("rc_next_index", next_index, 0);
    check("rc_count", match_count, 0);
    check("rc_tvalid", m_axis_tvalid, 0);
    step(1'b0);
    check("rc_capture_after", next_index, 1);
    check("rc_count_after", match_count, 1);
    drain(50, 1'b0);

    // Synchronous reset in the middle of a burst.
    do_reload();
    load_packet(5);
    repeat (5) step(1'b1);
    rst = 1'b1;
    model_clear();
    step(1'b1);
    check("rb_next_index", next_index, 0);
    check("rb_tvalid", m_axis_tvalid, 0);
    check("rb_count", match_count, 0);
    check("rb_overflow", overflow, 0);
    check("rb_busy", busy, 0);
    rst = 1'b0;
    step(1'b1);
    check("rb_no_pulse", next_index, 0);

    // Randomized packets with a randomly stalling sink.
    for (int p = 0; p < 8; p++) begin
      int n, want;
      do_reload();
      n = $urandom_range(1, MAX + 4);
      want = (n > MAX) ? MAX : n;
      load_packet(n);
      drain(2000, 1'b1);
      repeat (3) step(1'b1);
      check("rnd_count", match_count, want);
      check("rnd_overflow", overflow, (n > MAX) ? 1 : 0);
      check("rnd_pulses", pulses, want);
      check("rnd_stream_done", exp_q.size(), 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/sme_match_collector.md
Name: sme_match_collector

Overview:
- Sits directly downstream of pigasus_sme_wrapper.
- Drains the wrapper's one-at-a-time match report (match_index/match_valid) by pulsing next_index, and buffers the 16-bit rule indices in a small FIFO.
- Presents the buffered indices as an AXI-Stream to the core-side match reader.
- Enforces a per-packet match limit and flags overflow; cleared by the same reload pulse that re-arms the wrapper.

Parameters:
- DEPTH, 8, FIFO entries (power of 2, ≥2).
- MAX_MATCHES, 32, per-packet capture limit (1..255).
- HOLDOFF, 2, cycles to ignore match_valid after a capture, covering the wrapper's next_index→match_valid update latency.
- CNT_W, 8, width of match_count.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- reload  in  1  new packet context; same pulse as the wrapper's reload
- match_index  in  16  rule index from the wrapper
- match_valid  in  1  match_index is valid
- next_index  out  1  one-cycle pulse: consume the current index
- m_axis_tdata  out  16  buffered rule index
- m_axis_tvalid  out  1  FIFO non-empty
- m_axis_tready  in  1  downstream accept
- match_count  out  CNT_W  indices captured since the last reload/rst
- overflow  out  1  sticky: a match was left unread because the limit was hit
- busy  out  1  state != IDLE or FIFO non-empty

Behaviour:
- Reset (rst), all outputs: next_index=0, m_axis_tvalid=0, match_count=0, overflow=0, busy=0; state=IDLE; FIFO empty.
- Reload:
  - Same effect as rst on state, FIFO (flush), match_count and overflow.
  - Reload has priority over a capture in the same cycle: no FIFO write, no next_index.
  - Reload mid-HOLD → IDLE on the next cycle.
- States: IDLE, HOLD.
- IDLE, capture condition: match_valid && !fifo_full && match_count<MAX_MATCHES.
  - Write match_index into the FIFO this cycle.
  - next_index<=1, so next_index is high in cycle t+1 for exactly one cycle.
  - match_count++.
  - hold_cnt<=HOLDOFF; go to HOLD.
- IDLE, FIFO full: no capture and no next_index; wait. Backpressure only; never sets overflow.
- IDLE, limit reached: if match_valid && match_count==MAX_MATCHES, set overflow=1. No next_index; the index is left in the wrapper.
- HOLD:
  - Decrement hold_cnt each cycle; match_valid is ignored.
  - Go to IDLE when hold_cnt reaches 1, so the next possible capture cycle is t+HOLDOFF+1.
  - With HOLDOFF=2, back-to-back captures happen every 3 cycles.
- Output side:
  - FIFO first-word-fall-through.
  - m_axis_tdata/tvalid are stable until m_axis_tready.
  - Pop on tvalid&&tready.
  - Simultaneous push and pop when full is not allowed: the capture condition is evaluated against the pre-pop full flag.
  - Push and pop in the same cycle when non-empty and not full are both honoured; occupancy is unchanged.
- Captured-write latency: capture cycle t → m_axis_tvalid high at t+1 if the FIFO was empty.
- match_count saturates at MAX_MATCHES and never wraps.
- Index value 0 is passed through unmodified; no filtering.

Decomposition:
- Shared package sme_pkg holds:
  - MATCH_IDX_W=16.
  - The collector state enum {IDLE, HOLD}.
  - The default HOLDOFF constant (2), shared with the wrapper's latency documentation.
- One sub-module: simple_fifo (ADDR_WIDTH=log2(DEPTH), DATA_WIDTH=16), with clear tied to reload.

Test Plan:
- Single match: match_valid=1 with index 0x0123, then match_valid=0 from t+3 → next_index high at t+1 only; m_axis 0x0123 at t+1; match_count=1; busy=0 after the pop.
- Burst: the wrapper model reports 0x0010, 0x0020, 0x0030, dropping match_valid 2 cycles after each next_index; tready=1 → three next_index pulses spaced 3 cycles apart; output order 0x0010, 0x0020, 0x0030; count=3.
- Backpressure: tready=0, 9 pending matches, DEPTH=8 → 8 captures, then next_index stays 0 and overflow=0; raise tready → the 9th is captured after the first pop.
- Limit: MAX_MATCHES=4, 6 matches → count=4, overflow=1 sticky, only 4 next_index pulses.
- Reload mid-HOLD with 2 entries in the FIFO → next cycle: m_axis_tvalid=0, count=0, overflow=0, state IDLE. Reload coincident with match_valid → no capture.
- rst asserted during a burst → all outputs at reset values the next cycle; no next_index pulse.
